// File: rtl/l4_decode_ctl_if.sv
// Command/decoder bundle between the two requesters and l4_decode_ctl.
// master = requester side, slave = the sequencer.
interface l4_decode_ctl_if #(parameter int DEC_INBITS = 4);
    logic                  req0, req1;
    logic [1:0]            op0, op1;
    logic [DEC_INBITS-1:0] rlo0, rhi0, clo0, chi0;
    logic [DEC_INBITS-1:0] rlo1, rhi1, clo1, chi1;
    logic                  gnt0, gnt1;
    logic                  done0, done1;
    logic                  busy;
    logic [2:0]            row_sel_range, col_sel_range;
    logic [DEC_INBITS-1:0] row_lower, row_upper, col_lower, col_upper;
    logic                  dec_valid;
    logic [DEC_INBITS-1:0] dec_row;

    modport master (
        output req0, req1, op0, op1,
        output rlo0, rhi0, clo0, chi0, rlo1, rhi1, clo1, chi1,
        input  gnt0, gnt1, done0, done1, busy,
        input  row_sel_range, col_sel_range,
        input  row_lower, row_upper, col_lower, col_upper,
        input  dec_valid, dec_row
    );

    modport slave (
        input  req0, req1, op0, op1,
        input  rlo0, rhi0, clo0, chi0, rlo1, rhi1, clo1, chi1,
        output gnt0, gnt1, done0, done1, busy,
        output row_sel_range, col_sel_range,
        output row_lower, row_upper, col_lower, col_upper,
        output dec_valid, dec_row
    );
endinterface

// File: rtl/l4_decode_ctl.sv
// Round-robin sequencer for the L4 row/column decoder pair.
// Optional macro L4_SWEEP_EN builds the multi-step row sweep for op 10.

module l4_bound_norm #(parameter int W = 4) (
    input  logic [W-1:0] lo,
    input  logic [W-1:0] hi,
    output logic [W-1:0] n_lo,
    output logic [W-1:0] n_hi
);
    assign n_lo = (lo > hi) ? hi : lo;
    assign n_hi = (lo > hi) ? lo : hi;
endmodule

module l4_decode_ctl #(parameter int DEC_INBITS = 4) (
    input  logic            clk,
    input  logic            reset,
    l4_decode_ctl_if.slave  bus
);
    localparam int W = DEC_INBITS;
    localparam int NUM_REQ = 2;
    localparam logic [W-1:0] ONE = W'(1);

    localparam logic [1:0] OP_CELL  = 2'b00;
    localparam logic [1:0] OP_RECT  = 2'b01;
    localparam logic [1:0] OP_SWEEP = 2'b10;
    localparam logic [1:0] OP_ALL   = 2'b11;

    localparam logic [2:0] SEL_DIS = 3'b000;
    localparam logic [2:0] SEL_LOW = 3'b001;
    localparam logic [2:0] SEL_RNG = 3'b011;
    localparam logic [2:0] SEL_ALL = 3'b100;

    typedef enum logic [1:0] {IDLE, DRIVE, SETTLE} state_t;

    typedef struct packed {
        logic [1:0]   op;
        logic [W-1:0] rlo;
        logic [W-1:0] rhi;
        logic [W-1:0] clo;
        logic [W-1:0] chi;
    } cmd_t;

    logic [NUM_REQ-1:0][1:0]   op_v;
    logic [NUM_REQ-1:0][W-1:0] rlo_v, rhi_v, clo_v, chi_v;
    logic [NUM_REQ-1:0][W-1:0] rlo_n, rhi_n, clo_n, chi_n;
    cmd_t                      cand [NUM_REQ];

    assign op_v  = {bus.op1,  bus.op0};
    assign rlo_v = {bus.rlo1, bus.rlo0};
    assign rhi_v = {bus.rhi1, bus.rhi0};
    assign clo_v = {bus.clo1, bus.clo0};
    assign chi_v = {bus.chi1, bus.chi0};

    // Bounds are normalised before capture so the decoder always sees lower <= upper.
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
        l4_bound_norm #(.W(W)) u_row_norm (
            .lo(rlo_v[g]), .hi(rhi_v[g]), .n_lo(rlo_n[g]), .n_hi(rhi_n[g])
        );
        l4_bound_norm #(.W(W)) u_col_norm (
            .lo(clo_v[g]), .hi(chi_v[g]), .n_lo(clo_n[g]), .n_hi(chi_n[g])
        );
        assign cand[g] = '{op: op_v[g], rlo: rlo_n[g], rhi: rhi_n[g],
                           clo: clo_n[g], chi: chi_n[g]};
    end

    state_t       state;
    cmd_t         cmd;
    logic [W-1:0] cur;
    logic         owner;
    logic         last_gnt;

    logic [1:0]   gnt_q, done_q;
    logic         busy_q, dec_valid_q;
    logic [W-1:0] dec_row_q;
    logic [2:0]   row_sel_q, col_sel_q;
    logic [W-1:0] row_lo_q, row_hi_q, col_lo_q, col_hi_q;

    // Contention goes to whoever did not win last time; last_gnt resets to 1.
    logic req_any, win;
    assign req_any = bus.req0 | bus.req1;
    assign win     = (bus.req0 & bus.req1) ? ~last_gnt : bus.req1;

    logic last_step;
`ifdef L4_SWEEP_EN
    assign last_step = (cmd.op != OP_SWEEP) || (cur == cmd.rhi);
`else
    assign last_step = 1'b1;
`endif

    // Decoder settings for the step about to be driven: the first step while
    // granting from IDLE, the following sweep row while in DRIVE.
    cmd_t         src;
    logic [2:0]   n_row_sel, n_col_sel;
    logic [W-1:0] n_row_lo, n_row_hi, n_col_lo, n_col_hi;

    always_comb begin
        src       = (state == IDLE) ? cand[win] : cmd;
        n_row_sel = SEL_DIS;
        n_col_sel = SEL_DIS;
        n_row_lo  = '0;
        n_row_hi  = '0;
        n_col_lo  = '0;
        n_col_hi  = '0;
        case (src.op)
            OP_CELL: begin
                n_row_sel = SEL_LOW;
                n_row_lo  = src.rlo;
                n_col_sel = SEL_LOW;
                n_col_lo  = src.clo;
            end
            OP_ALL: begin
                n_row_sel = SEL_ALL;
                n_col_sel = SEL_ALL;
            end
`ifdef L4_SWEEP_EN
            OP_SWEEP: begin
                n_row_sel = SEL_LOW;
                n_row_lo  = (state == IDLE) ? src.rlo : cur + ONE;
                n_col_sel = SEL_RNG;
                n_col_lo  = src.clo;
                n_col_hi  = src.chi;
            end
`endif
            default: begin
                n_row_sel = SEL_RNG;
                n_row_lo  = src.rlo;
                n_row_hi  = src.rhi;
                n_col_sel = SEL_RNG;
                n_col_lo  = src.clo;
                n_col_hi  = src.chi;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cmd         <= '0;
            cur         <= '0;
            owner       <= 1'b0;
            last_gnt    <= 1'b1;
            gnt_q       <= '0;
            done_q      <= '0;
            busy_q      <= 1'b0;
            dec_valid_q <= 1'b0;
            dec_row_q   <= '0;
            row_sel_q   <= SEL_DIS;
            col_sel_q   <= SEL_DIS;
            row_lo_q    <= '0;
            row_hi_q    <= '0;
            col_lo_q    <= '0;
            col_hi_q    <= '0;
        end else begin
            gnt_q       <= '0;
            done_q      <= '0;
            dec_valid_q <= (state == DRIVE);
            dec_row_q   <= cur;
            case (state)
                IDLE: begin
                    if (req_any) begin
                        state      <= DRIVE;
                        cmd        <= cand[win];
                        cur        <= cand[win].rlo;
                        owner      <= win;
                        last_gnt   <= win;
                        gnt_q[win] <= 1'b1;
                        busy_q     <= 1'b1;
                        row_sel_q  <= n_row_sel;
                        col_sel_q  <= n_col_sel;
                        row_lo_q   <= n_row_lo;
                        row_hi_q   <= n_row_hi;
                        col_lo_q   <= n_col_lo;
                        col_hi_q   <= n_col_hi;
                    end
                end
                DRIVE: begin
                    if (last_step) begin
                        state         <= SETTLE;
                        done_q[owner] <= 1'b1;
                        row_sel_q     <= SEL_DIS;
                        col_sel_q     <= SEL_DIS;
                    end else begin
                        // cur == rhi ends the sweep, so cur never wraps past the top row.
                        cur       <= cur + ONE;
                        row_sel_q <= n_row_sel;
                        col_sel_q <= n_col_sel;
                        row_lo_q  <= n_row_lo;
                        row_hi_q  <= n_row_hi;
                        col_lo_q  <= n_col_lo;
                        col_hi_q  <= n_col_hi;
                    end
                end
                SETTLE: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.gnt0          = gnt_q[0];
    assign bus.gnt1          = gnt_q[1];
    assign bus.done0         = done_q[0];
    assign bus.done1         = done_q[1];
    assign bus.busy          = busy_q;
    assign bus.row_sel_range = row_sel_q;
    assign bus.col_sel_range = col_sel_q;
    assign bus.row_lower     = row_lo_q;
    assign bus.row_upper     = row_hi_q;
    assign bus.col_lower     = col_lo_q;
    assign bus.col_upper     = col_hi_q;
    assign bus.dec_valid     = dec_valid_q;
    assign bus.dec_row       = dec_row_q;
endmodule

// File: doc/l4_decode_ctl.md
Name: l4_decode_ctl

Overview:
Sequencer and arbiter for the L4 row/column decoder pair in the maze-routing array. Two requesters (0 = host/PCI side, 1 = router FSM) share the decoders. The block accepts select commands from either requester and drives sel_range/lower/upper for the row decoder and the column decoder. It also steps row-by-row sweeps, and flags when the registered decoder outputs are valid.

Parameters:
DEC_INBITS, 4, width of row/column index (array is 2^DEC_INBITS per side)

Ports:
clk  in  1  clock, all logic on posedge
reset  in  1  synchronous, active-high reset
req0, req1  in  1  request; held high until the matching gnt
op0, op1  in  2  command: 00 cell, 01 rectangle, 10 row sweep, 11 all
rlo0, rhi0, clo0, chi0  in  DEC_INBITS  requester 0 row/col bounds
rlo1, rhi1, clo1, chi1  in  DEC_INBITS  requester 1 row/col bounds
gnt0, gnt1  out  1  one-cycle pulse; command captured
done0, done1  out  1  one-cycle pulse with last dec_valid of that requester's command
busy  out  1  high in any state other than IDLE
row_sel_range, col_sel_range  out  3  decoder mode: 000 disable, 001 lower, 010 upper, 011 range, 100 all
row_lower, row_upper, col_lower, col_upper  out  DEC_INBITS  decoder bounds
dec_valid  out  1  decoder outputs (one clock after drive) reflect a command step
dec_row  out  DEC_INBITS  row index of current dec_valid step (sweep); row lower bound otherwise

Behaviour:
- All outputs are registered. Reset value of every output is 0, so sel_range = 000 (disable). Reset also forces state IDLE and sets last_gnt = 1.
- States: IDLE, DRIVE, SETTLE.
- IDLE: arbitration is sampled at each edge.
  - Only one req high: that requester wins.
  - Both high: the requester other than last_gnt wins (round-robin). The first contention after reset goes to 0.
  - Winner: capture its op and bounds, pulse its gnt, update last_gnt, go to DRIVE.
  - Decoder outputs for the first step are valid in the same cycle as gnt.
- Bound normalisation at capture: if lo > hi for rows or columns, swap that pair so lower <= upper.
- Mapping in DRIVE:
  - cell: row 001 with row_lower = rlo; col 001 with col_lower = clo.
  - rectangle: row 011 (rlo..rhi); col 011 (clo..chi).
  - sweep: row 001 with row_lower = cur; col 011 (clo..chi).
  - all: row 100, col 100.
- Sweep: cur starts at rlo and increments by one per cycle while in DRIVE. When cur == rhi, the next state is SETTLE. A sweep with rlo == rhi takes one step. Full-range sweep 0..2^DEC_INBITS-1 must not wrap; the cur == rhi compare terminates it.
- Non-sweep ops spend exactly one cycle in DRIVE.
- SETTLE: decoder outputs return to 000. Last dec_valid asserts with done(n) for the owning requester. Next state is IDLE.
- dec_valid and dec_row are a one-cycle-delayed copy of "in DRIVE" and cur. They align with the decoder's registered decout.
- Latency: gnt at cycle T, first dec_valid at T+1, done at T+N, where N = steps (1 for cell/rect/all; rhi-rlo+1 for sweep). IDLE again at T+N+1. A new grant is possible at the edge ending cycle T+N+1.
- Requests raised while busy are held off and arbitrated only in IDLE. gnt is never asserted while busy is high except in the grant cycle.
- Reset mid-operation: next cycle is IDLE, decoders disabled, no done pulse. The pending requester must re-request.
- op and bounds inputs are ignored except at the grant edge.

Optional Feature:
L4_SWEEP_EN:
- Defined: op 10 performs the row sweep described above.
- Undefined: sweep logic is not built. op 10 executes as rectangle (one step, done at T+1), and dec_row always equals the captured rlo.

Test Plan:
1. req0, op=00, rlo=3, clo=5 -> gnt0 at T; row_sel 001 / row_lower 3, col_sel 001 / col_lower 5 at T; dec_valid + done0 at T+1; busy low at T+2.
2. req1, op=01, rlo=9, rhi=2, clo=4, chi=4 -> swapped to row range 2..9, col 4..4 (sel 011); done1 at T+1.
3. req0, op=10, rlo=14, rhi=15 (L4_SWEEP_EN) -> row_lower 14, 15 on T, T+1; dec_row 14, 15 on T+1, T+2; done0 at T+2 only. Repeat with rlo=rhi=15: single step; and 0..15: 16 steps, no wrap.
4. req0 and req1 high together from reset -> gnt0 first. req1 held high and granted after done0 plus the IDLE cycle. Next simultaneous pair -> gnt0 (last_gnt was 1).
5. reset asserted during step 3 of a 0..15 sweep -> next cycle all outputs 0, busy 0, no done0.
6. Build without L4_SWEEP_EN, op=10, rlo=1, rhi=6 -> row_sel 011 (1..6), single dec_valid, done at T+1.
